// File: rtl/bram_ctrl_pkg.sv
// bram_ctrl_pkg
//   Shared types for the block-RAM port controller.
//   ctrl_state_t : controller mode, either zero-filling the RAM (CLEAR)
//                  or serving client requests (RUN).
package bram_ctrl_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ctrl_state_t;

  // Response buffer capacity; the credit check in the top level keeps
  // requests-in-progress at or below this.
  localparam int unsigned RspSlots = 2;

endpackage

// File: rtl/bram_port_ctrl_resp_fifo2.sv
// resp_fifo2
//   Two-entry synchronous FIFO holding read data on its way back to the
//   client. Data leaves in the order it was pushed.
// Ports
//   clk     in   clock
//   rst     in   synchronous active-high reset, empties the FIFO
//   push_i  in   write data_i at the end of this cycle
//   data_i  in   data to push
//   pop_i   in   drop the head entry at the end of this cycle
//   occ_o   out  number of entries held (0..2)
//   head_o  out  oldest entry; meaningless while occ_o == 0
module resp_fifo2 #(
  parameter int Width = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [1:0]       occ_o,
  output logic [Width-1:0] head_o
);

  logic [Width-1:0] mem_q [2];
  logic             wrPtr_q;
  logic             rdPtr_q;
  logic [1:0]       occ_q;
  logic [1:0]       occ_d;

  // Occupancy bookkeeping; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    occ_d = occ_q;
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= 1'b0;
      rdPtr_q <= 1'b0;
      occ_q   <= 2'd0;
    end else begin
      if (push_i) wrPtr_q <= ~wrPtr_q;
      if (pop_i)  rdPtr_q <= ~rdPtr_q;
      occ_q <= occ_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wrPtr_q] <= data_i;
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rdPtr_q];

endmodule

// File: rtl/bram_port_ctrl.sv
// bram_port_ctrl
//   Initiator-side controller for one single-port, read-first block RAM
//   with one cycle of read latency. Client reads and writes arrive over a
//   valid/ready channel; read data returns in order through a 2-entry
//   buffer. After reset, or on clr_start, the whole RAM is zero-filled.
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_wen               1 = write, 0 = read
//   req_addr, req_wdata   request address and write data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             head of the response buffer
//   clr_start             one-cycle pulse requesting a zero-fill
//   busy                  high while a zero-fill is in progress
//   bram_en/wen/addr/din  RAM command
//   bram_dout             RAM read data, one cycle after a read enable
module bram_port_ctrl
  import bram_ctrl_pkg::*;
#(
  parameter  int Depth = 512,
  parameter  int Width = 36,
  localparam int AW    = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wen,
  input  logic [AW-1:0]    req_addr,
  input  logic [Width-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [Width-1:0] rsp_rdata,
  input  logic             clr_start,
  output logic             busy,
  output logic             bram_en,
  output logic             bram_wen,
  output logic [AW-1:0]    bram_addr,
  output logic [Width-1:0] bram_din,
  input  logic [Width-1:0] bram_dout
);

  ctrl_state_t      state_q, state_d;
  logic [AW-1:0]    clrAddr_q, clrAddr_d;
  logic             inflight_q, inflight_d;
  logic [1:0]       occ;
  logic [Width-1:0] fifoHead;
  logic             accept;
  logic             pop;
  logic [2:0]       slotsUsed;

  // Next-state logic. CLEAR walks every address once; clr_start only
  // matters in RUN so a second pulse cannot restart a clear in progress.
  always_comb begin
    state_d   = state_q;
    clrAddr_d = clrAddr_q;
    case (state_q)
      CLEAR: begin
        clrAddr_d = clrAddr_q + AW'(1);
        if (clrAddr_q == AW'(Depth - 1)) begin
          state_d   = RUN;
          clrAddr_d = '0;
        end
      end
      RUN: begin
        if (clr_start) begin
          state_d   = CLEAR;
          clrAddr_d = '0;
        end
      end
      default: begin
        state_d   = CLEAR;
        clrAddr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clrAddr_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clrAddr_q  <= clrAddr_d;
      inflight_q <= inflight_d;
    end
  end

  // Response outputs are forced low during reset so a stale buffer is never
  // presented while the FIFO is being emptied.
  assign rsp_valid = !rst && (occ != 2'd0);
  assign pop       = rsp_valid && rsp_ready;
  assign busy      = rst || (state_q == CLEAR);

  // Credit check: buffered entries plus the read currently in the RAM pipe,
  // less the entry leaving this cycle, must leave room for one more. The
  // check ignores req_wen so writes and reads see the same ready.
  assign slotsUsed = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign req_ready = !rst && (state_q == RUN) && !clr_start
                     && (slotsUsed < 3'(RspSlots));
  assign accept    = req_valid && req_ready;

  // A read issued this cycle has its data on bram_dout next cycle.
  assign inflight_d = accept && !req_wen;

  // RAM command mux: clear writes take priority, otherwise the accepted
  // request passes straight through.
  always_comb begin
    bram_en   = 1'b0;
    bram_wen  = 1'b0;
    bram_addr = req_addr;
    bram_din  = req_wdata;
    if (!rst) begin
      if (state_q == CLEAR) begin
        bram_en   = 1'b1;
        bram_wen  = 1'b1;
        bram_addr = clrAddr_q;
        bram_din  = '0;
      end else if (accept) begin
        bram_en  = 1'b1;
        bram_wen = req_wen;
      end
    end
  end

  // Capture runs independently of state so a read issued just before a
  // clear still lands in the buffer.
  resp_fifo2 #(
    .Width(Width)
  ) uRespFifo (
    .clk   (clk),
    .rst   (rst),
    .push_i(inflight_q),
    .data_i(bram_dout),
    .pop_i (pop),
    .occ_o (occ),
    .head_o(fifoHead)
  );

  assign rsp_rdata = fifoHead;

endmodule

// File: tb/tb_bram_port_ctrl.sv
// tb_bram_port_ctrl
//   Directed and random bench for bram_port_ctrl with a read-first RAM
//   attached. Expected behaviour comes from a transaction-level model: an
//   array of memory contents plus a queue of pending responses tagged with
//   the cycle at which they become visible.
module tb_bram_port_ctrl;

  localparam int Depth = 512;
  localparam int Width = 36;
  localparam int AW    = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             reqValid;
  logic             reqReady;
  logic             reqWen;
  logic [AW-1:0]    reqAddr;
  logic [Width-1:0] reqWdata;
  logic             rspValid;
  logic             rspReady;
  logic [Width-1:0] rspRdata;
  logic             clrStart;
  logic             busy;
  logic             bramEn;
  logic             bramWen;
  logic [AW-1:0]    bramAddr;
  logic [Width-1:0] bramDin;
  logic [Width-1:0] bramDout;

  always #5 clk = ~clk;

  bram_port_ctrl #(
    .Depth(Depth),
    .Width(Width)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(reqValid),
    .req_ready(reqReady),
    .req_wen  (reqWen),
    .req_addr (reqAddr),
    .req_wdata(reqWdata),
    .rsp_valid(rspValid),
    .rsp_ready(rspReady),
    .rsp_rdata(rspRdata),
    .clr_start(clrStart),
    .busy     (busy),
    .bram_en  (bramEn),
    .bram_wen (bramWen),
    .bram_addr(bramAddr),
    .bram_din (bramDin),
    .bram_dout(bramDout)
  );

  // Read-first single-port RAM with registered output.
  logic [Width-1:0] ram [Depth];
  always @(posedge clk) begin
    if (bramEn) begin
      if (bramWen) ram[bramAddr] <= bramDin;
      bramDout <= ram[bramAddr];
    end
  end

  // Reference model state.
  typedef struct {
    logic [Width-1:0] data;
    int               visibleCyc;
  } rsp_t;

  logic [Width-1:0] refMem [Depth];
  rsp_t             rspQ [$];
  int               cyc     = 0;
  int               clrLeft = Depth;
  int               clrNext = 0;
  bit               lastAccepted;

  int errors = 0;
  int checks = 0;

  // Observed DUT activity, used by the directed checks.
  int               dutAccepts    = 0;
  int               dutPops       = 0;
  int               dutZeroWrites = 0;
  logic [Width-1:0] lastPopData;

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic w,
                               input logic [AW-1:0] a,
                               input logic [Width-1:0] d,
                               input logic rr, input logic cs);
    reqValid = v;
    reqWen   = w;
    reqAddr  = a;
    reqWdata = d;
    rspReady = rr;
    clrStart = cs;
  endtask

  // One clock cycle: check every output at the falling edge against the
  // model, then advance the model across the rising edge.
  task automatic tick();
    int   occ;
    bit   infl, inClear, expValid, expReady, pop, acc;
    logic [63:0] obsCmd, expCmd;
    @(negedge clk);
    occ = 0;
    for (int i = 0; i < rspQ.size(); i++)
      if (rspQ[i].visibleCyc <= cyc) occ++;
    infl     = (rspQ.size() > 0) && (rspQ[rspQ.size()-1].visibleCyc == cyc + 1);
    inClear  = !rst && (clrLeft > 0);
    expValid = !rst && (occ > 0);
    pop      = expValid && rspReady;
    expReady = !rst && !inClear && !clrStart
               && ((occ + int'(infl) - int'(pop)) < 2);
    acc      = reqValid && expReady;

    checkOutput("busy", 64'(busy), 64'(rst || (clrLeft > 0)));
    checkOutput("req_ready", 64'(reqReady), 64'(expReady));
    checkOutput("rsp_valid", 64'(rspValid), 64'(expValid));
    if (expValid) checkOutput("rsp_rdata", 64'(rspRdata), 64'(rspQ[0].data));
    checkOutput("bram_en", 64'(bramEn), 64'(inClear || acc));
    obsCmd = 64'({bramWen, bramAddr, bramDin});
    if (inClear) begin
      expCmd = 64'({1'b1, AW'(clrNext), Width'(0)});
      checkOutput("bram_clear_cmd", obsCmd, expCmd);
    end else if (acc) begin
      expCmd = 64'({reqWen, reqAddr, reqWdata});
      checkOutput("bram_req_cmd", obsCmd, expCmd);
    end

    if (reqValid && reqReady) dutAccepts++;
    if (rspValid && rspReady) begin
      dutPops++;
      lastPopData = rspRdata;
    end
    if (bramEn && bramWen && busy && (bramDin == '0)) dutZeroWrites++;

    @(posedge clk);
    if (rst) begin
      rspQ.delete();
      clrLeft = Depth;
      clrNext = 0;
    end else begin
      if (pop) void'(rspQ.pop_front());
      if (inClear) begin
        refMem[clrNext] = '0;
        clrNext++;
        clrLeft--;
      end else if (clrStart) begin
        clrLeft = Depth;
        clrNext = 0;
      end else if (acc) begin
        if (reqWen) refMem[reqAddr] = reqWdata;
        else rspQ.push_back('{data: refMem[reqAddr], visibleCyc: cyc + 2});
      end
    end
    lastAccepted = acc;
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, rr, 1'b0);
      tick();
    end
  endtask

  initial begin
    int           base;
    logic [AW-1:0] a;

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    // Reset, then the power-up zero-fill of every address.
    tick();
    tick();
    rst = 1'b0;
    dutZeroWrites = 0;
    idle(Depth, 1'b1);
    checkOutput("init_clear_writes", 64'(dutZeroWrites), 64'(Depth));
    idle(1, 1'b1);

    // Write then immediately read the same address.
    applyStimulus(1'b1, 1'b1, AW'(5), 36'h123456789, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, AW'(5), '0, 1'b1, 1'b0);
    tick();
    idle(2, 1'b1);
    checkOutput("raw_data", 64'(lastPopData), 64'h123456789);

    // Back-to-back writes then reads of addresses 0..15.
    base = dutAccepts;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, AW'(i), Width'(i), 1'b1, 1'b0);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0);
      tick();
    end
    checkOutput("b2b_accepts", 64'(dutAccepts - base), 64'd32);
    base = dutPops;
    idle(3, 1'b1);
    checkOutput("b2b_last_data", 64'(lastPopData), 64'd15);

    // Back-pressure: only two reads fit while the client stalls.
    base = dutAccepts;
    a = AW'(3);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, a, '0, 1'b0, 1'b0);
      tick();
      if (lastAccepted) a = a + AW'(1);
    end
    checkOutput("stall_accepts", 64'(dutAccepts - base), 64'd2);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, a, '0, 1'b1, 1'b0);
      tick();
      if (lastAccepted) a = a + AW'(1);
    end
    idle(3, 1'b1);

    // Clear with one entry buffered and one read in the RAM pipe.
    applyStimulus(1'b1, 1'b0, AW'(7), '0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, AW'(8), '0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    base = dutPops;
    dutZeroWrites = 0;
    idle(Depth, 1'b1);
    checkOutput("clear_pops", 64'(dutPops - base), 64'd2);
    checkOutput("clear_writes", 64'(dutZeroWrites), 64'(Depth));
    applyStimulus(1'b1, 1'b0, AW'(5), '0, 1'b1, 1'b0);
    tick();
    lastPopData = '1;
    idle(3, 1'b1);
    checkOutput("after_clear_data", 64'(lastPopData), 64'd0);

    // Reset during a clear with the buffer full.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, AW'(20 + i), Width'(36'hABC00 + i), 1'b1, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 1'b0, AW'(20), '0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, AW'(21), '0, 1'b0, 1'b0);
    tick();
    idle(2, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    idle(100, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_flush_valid", 64'(rspValid), 64'd0);
    dutZeroWrites = 0;
    idle(Depth, 1'b1);
    checkOutput("rst_clear_writes", 64'(dutZeroWrites), 64'(Depth));
    idle(1, 1'b1);

    // Random traffic over a small address window, with occasional clears.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, 31)), Width'({$urandom, $urandom}),
                    1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 299) == 0));
      tick();
    end
    idle(Depth + 8, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
